// File: rtl/alu_pkg.sv
// alu_mc shared definitions: opcodes, FSM state, multicycle decode.
// No ports; imported by alu_mc and alu_mc_iter.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6;
  localparam logic [4:0] OP_INC  = 5'd7;
  localparam logic [4:0] OP_DEC  = 5'd8;
  localparam logic [4:0] OP_RL   = 5'd9;
  localparam logic [4:0] OP_RR   = 5'd10;
  localparam logic [4:0] OP_RLC  = 5'd11;
  localparam logic [4:0] OP_RRC  = 5'd12;
  localparam logic [4:0] OP_SWAP = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// W-step shift-add multiply / restoring divide datapath.
// Ports: i_start loads operands (i_div selects divide); o_done marks the
// last step, o_lo/o_hi are that step's results, o_dz flags a zero divisor.
import alu_pkg::*;

module alu_mc_iter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_div,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic         o_div,
  output logic         o_dz,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_hi
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_W = CW'(W);

  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_m;
  logic [CW-1:0] r_cnt;
  logic          r_div;

  logic [W:0]   w_msum;
  logic [W:0]   w_rsh;
  logic         w_ge;
  logic [W-1:0] w_rdif;
  logic [W-1:0] w_acc_nxt;
  logic [W-1:0] w_q_nxt;

  // mul: {acc,q} holds partial product, multiplier bits leave from q[0].
  // div: {acc,q} shifts left, remainder in acc, quotient bits enter q[0].
  assign w_msum = {1'b0, r_acc} + {1'b0, r_m};
  assign w_rsh  = {r_acc, r_q[W-1]};
  assign w_ge   = w_rsh >= {1'b0, r_m};
  // difference is < r_m whenever used, so the low W bits suffice
  assign w_rdif = w_rsh[W-1:0] - r_m;

  always_comb begin
    w_acc_nxt = r_acc;
    w_q_nxt   = r_q;
    if (r_div) begin
      w_acc_nxt = w_ge ? w_rdif : w_rsh[W-1:0];
      w_q_nxt   = {r_q[W-2:0], w_ge};
    end else if (r_q[0]) begin
      w_acc_nxt = w_msum[W:1];
      w_q_nxt   = {w_msum[0], r_q[W-1:1]};
    end else begin
      w_acc_nxt = {1'b0, r_acc[W-1:1]};
      w_q_nxt   = {r_acc[0], r_q[W-1:1]};
    end
  end

  assign o_done = (r_cnt == CW'(1));
  assign o_div  = r_div;
  assign o_dz   = (r_m == '0);
  assign o_lo   = w_q_nxt;
  assign o_hi   = w_acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (i_start) begin
      r_acc <= '0;
      r_q   <= i_a;
      r_m   <= i_b;
      r_cnt <= CNT_W;
      r_div <= i_div;
    end else if (r_cnt != '0) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// W-bit multicycle ALU: single-cycle logic/arith, iterative MUL/DIV.
// Ports: in_valid/in_ready accept, op/op1/op2/cpu_carry request,
// out_valid pulse with registered result_l/result_h and carry/zero/sign.
import alu_pkg::*;

module alu_mc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic         cpu_carry,
  output logic         out_valid,
  output logic [W-1:0] result_l,
  output logic [W-1:0] result_h,
  output logic         carry,
  output logic         zero,
  output logic         sign
);

  state_t r_state;

  logic         w_acc;
  logic         w_multi;
  logic         w_start;
  logic         w_done;
  logic         w_div;
  logic         w_dz;
  logic [W-1:0] w_ilo;
  logic [W-1:0] w_ihi;
  logic [W:0]   w_sum;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_z;
  logic         w_s;
  logic         w_legal;

  assign in_ready = (r_state == IDLE);
  assign w_acc    = in_valid && in_ready;
  assign w_multi  = is_multicycle(op);
  assign w_start  = w_acc && w_multi;

  // ADD and ADC share one adder; carry-in only for ADC
  assign w_sum = {1'b0, op1} + {1'b0, op2}
               + {{W{1'b0}}, (op == OP_ADC) && cpu_carry};

  always_comb begin
    w_res   = '0;
    w_c     = 1'b0;
    w_s     = 1'b0;
    w_legal = 1'b1;
    unique case (op)
      OP_ADD, OP_ADC: {w_c, w_res} = w_sum;
      OP_SUB: begin
        w_s   = op1 < op2;
        w_res = w_s ? op2 - op1 : op1 - op2;
      end
      OP_AND: w_res = op1 & op2;
      OP_OR:  w_res = op1 | op2;
      OP_XOR: w_res = op1 ^ op2;
      OP_NOT: w_res = ~op1;
      OP_INC: begin
        w_res = op1 + W'(1);
        w_c   = &op1;
      end
      OP_DEC: begin
        w_res = op1 - W'(1);
        w_s   = ~|op1;
      end
      OP_RL:  w_res = {op1[W-2:0], op1[W-1]};
      OP_RR:  w_res = {op1[0], op1[W-1:1]};
      OP_RLC: begin
        w_res = {op1[W-2:0], cpu_carry};
        w_c   = op1[W-1];
      end
      OP_RRC: begin
        w_res = {cpu_carry, op1[W-1:1]};
        w_c   = op1[0];
      end
      OP_SWAP: w_res = {op1[W/2-1:0], op1[W-1:W/2]};
      default: w_legal = 1'b0;
    endcase
    w_z = w_legal && (w_res == '0);
  end

  alu_mc_iter #(.W(W)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_div   (op == OP_DIV),
    .i_a     (op1),
    .i_b     (op2),
    .o_done  (w_done),
    .o_div   (w_div),
    .o_dz    (w_dz),
    .o_lo    (w_ilo),
    .o_hi    (w_ihi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
      result_l  <= '0;
      result_h  <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      sign      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            if (w_multi) begin
              r_state <= BUSY;
            end else begin
              result_l  <= w_res;
              result_h  <= '0;
              carry     <= w_c;
              zero      <= w_z;
              sign      <= w_s;
              out_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (w_done) begin
            r_state   <= IDLE;
            out_valid <= 1'b1;
            result_l  <= w_ilo;
            result_h  <= w_ihi;
            sign      <= 1'b0;
            if (w_div) begin
              carry <= w_dz;
              zero  <= (w_ilo == '0);
            end else begin
              carry <= |w_ihi;
              zero  <= ~|{w_ihi, w_ilo};
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: W=8 instance for function, W=16 for latency.
// Expected results queued at drive time, compared on out_valid.
module tb_alu_mc;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       s;
  } exp_t;

  logic        clk = 0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [7:0]  op1, op2;
  logic        cpu_carry;
  logic        out_valid;
  logic [7:0]  result_l, result_h;
  logic        carry, zero, sign;

  logic        in_valid16;
  logic        ready16;
  logic [15:0] a16, b16;
  logic        ov16;
  logic [15:0] rl16, rh16;
  logic        c16, z16, s16;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ov_cnt = 0;
  int   last_ov = 0;
  int   prev_ov = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mc #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op1(op1), .op2(op2), .cpu_carry(cpu_carry),
    .out_valid(out_valid), .result_l(result_l), .result_h(result_h),
    .carry(carry), .zero(zero), .sign(sign)
  );

  alu_mc #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(ready16),
    .op(op), .op1(a16), .op2(b16), .cpu_carry(cpu_carry),
    .out_valid(ov16), .result_l(rl16), .result_h(rh16),
    .carry(c16), .zero(z16), .sign(s16)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] lo, input logic [7:0] hi,
                              input logic c, input logic z, input logic s);
    exp_t e;
    e.lo = lo; e.hi = hi; e.c = c; e.z = z; e.s = s;
    return e;
  endfunction

  function automatic exp_t model(input logic [4:0] o, input logic [7:0] a,
                                 input logic [7:0] b, input logic ci);
    exp_t e;
    logic [8:0]  t;
    logic [15:0] p;
    e = '0;
    case (o)
      0:  begin t = a + b; e.lo = t[7:0]; e.c = t[8]; end
      1:  begin t = a + b + ci; e.lo = t[7:0]; e.c = t[8]; end
      2:  if (a < b) begin e.lo = b - a; e.s = 1; end else e.lo = a - b;
      3:  e.lo = a & b;
      4:  e.lo = a | b;
      5:  e.lo = a ^ b;
      6:  e.lo = ~a;
      7:  begin e.lo = a + 8'd1; e.c = (a == 8'hFF); end
      8:  begin e.lo = a - 8'd1; e.s = (a == 8'h00); end
      9:  e.lo = {a[6:0], a[7]};
      10: e.lo = {a[0], a[7:1]};
      11: begin e.lo = {a[6:0], ci}; e.c = a[7]; end
      12: begin e.lo = {ci, a[7:1]}; e.c = a[0]; end
      13: e.lo = {a[3:0], a[7:4]};
      14: begin
        p = a * b;
        e.lo = p[7:0]; e.hi = p[15:8];
        e.c = (p[15:8] != 0); e.z = (p == 0);
      end
      15: begin
        if (b == 0) begin e.lo = 8'hFF; e.hi = a; e.c = 1; end
        else begin e.lo = a / b; e.hi = a % b; end
        e.z = (e.lo == 0);
      end
      default: e = '0;
    endcase
    if (o < 14) e.z = (e.lo == 0);
    return e;
  endfunction

  task automatic wait_rdy();
    int g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) chk("rdy_timeout", 0, 1);
  endtask

  task automatic send(input logic [4:0] o, input logic [7:0] a,
                      input logic [7:0] b, input logic ci, input exp_t e);
    wait_rdy();
    op = o; op1 = a; op2 = b; cpu_carry = ci; in_valid = 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_ov", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("res_l", result_l, e.lo);
        chk("res_h", result_h, e.hi);
        chk("flags_czs", {carry, zero, sign}, {e.c, e.z, e.s});
      end
      ov_cnt++;
      prev_ov = last_ov;
      last_ov = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat, nb, ovb;
    bit got;
    logic [4:0] o;
    logic [7:0] a, b;
    logic ci;

    rst = 1; in_valid = 0; in_valid16 = 0; op = 0;
    op1 = 0; op2 = 0; cpu_carry = 0; a16 = 0; b16 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {result_l, result_h, carry, zero, sign, out_valid}, 0);
    chk("rst_rdy", in_ready, 1);
    rst = 0;
    @(posedge clk); #1;

    send(OP_ADD, 8'hF0, 8'h20, 0, mk(8'h10, 0, 1, 0, 0));
    send(OP_ADC, 8'h01, 8'h01, 1, mk(8'h03, 0, 0, 0, 0));
    @(negedge clk); #1;
    chk("b2b_ov_gap", last_ov - prev_ov, 1);
    @(posedge clk); #1;

    send(OP_SUB, 8'h05, 8'h09, 0, mk(8'h04, 0, 0, 0, 1));
    send(OP_SUB, 8'h07, 8'h07, 0, mk(8'h00, 0, 0, 1, 0));
    send(OP_DIV, 8'd200, 8'd7, 0, mk(8'h1C, 8'h04, 0, 0, 0));
    send(OP_DIV, 8'h55, 8'h00, 0, mk(8'hFF, 8'h55, 1, 0, 0));
    send(OP_RL, 8'h81, 0, 0, mk(8'h03, 0, 0, 0, 0));
    send(OP_RRC, 8'h81, 0, 0, mk(8'h40, 0, 1, 0, 0));
    send(OP_SWAP, 8'h3C, 0, 0, mk(8'hC3, 0, 0, 0, 0));
    send(5'd20, 8'h81, 8'h7E, 1, mk(0, 0, 0, 0, 0));
    send(OP_INC, 8'hFF, 0, 0, mk(8'h00, 0, 1, 1, 0));
    send(OP_DEC, 8'h00, 0, 0, mk(8'hFF, 0, 0, 0, 1));

    // MUL latency, in_valid held high through BUSY
    wait_rdy();
    op = OP_MUL; op1 = 8'hFF; op2 = 8'hFF; in_valid = 1;
    sb.push_back(mk(8'h01, 8'hFE, 1, 0, 0));
    @(posedge clk); #1;
    op = OP_ADD; op1 = 8'h11; op2 = 8'h22;
    lat = 1; nb = 0; got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1; in_valid = 0;
        chk("mul_rdy_at_ov", in_ready, 1);
      end else begin
        if (!in_ready) nb++;
        @(posedge clk); #1; lat++;
      end
    end
    chk("mul_latency", lat, 9);
    chk("mul_busy_cyc", nb, 8);
    @(posedge clk); #1;

    // reset during MUL aborts without out_valid
    wait_rdy();
    op = OP_MUL; op1 = 8'h05; op2 = 8'h06; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("abort_rdy", in_ready, 1);
    chk("abort_ov", out_valid, 0);
    @(negedge clk);
    rst = 0;
    ovb = ov_cnt;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_ov", ov_cnt, ovb);

    // W=16 MUL latency
    op = OP_MUL; a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1;
    @(posedge clk); #1;
    in_valid16 = 0;
    lat = 1; nb = 0; got = 0;
    while (!got && lat < 60) begin
      @(negedge clk);
      if (ov16) begin
        got = 1;
        chk("m16_rdy_at_ov", ready16, 1);
        chk("m16_lo", rl16, 16'h0001);
        chk("m16_hi", rh16, 16'hFFFE);
        chk("m16_flags", {c16, z16, s16}, 3'b100);
      end else begin
        if (!ready16) nb++;
        @(posedge clk); #1; lat++;
      end
    end
    chk("m16_latency", lat, 17);
    chk("m16_busy_cyc", nb, 16);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      o = 5'($urandom_range(0, 16));
      if (o == 5'd16) o = 5'(16 + $urandom_range(0, 15));
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      ci = 1'($urandom_range(0, 1));
      send(o, a, b, ci, model(o, a, b, ci));
    end

    repeat (20) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
